// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder controller: FSM state
//   encoding and the bit-counter width helper.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Bits needed to count 0..width-1 (at least one bit).
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell
//   Purely combinational 1-bit full-adder cell shared by the serial
//   controller, which feeds it one operand bit pair per clock.
// Ports:
//   x, y  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out (majority of x, y, ci)
module serial_fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Adds two WIDTH-bit operands LSB first through a single 1-bit adder
//   cell, one bit per clock. A start/busy/done handshake frames each
//   operation; sum/cout are held until the next completion.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf output).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   busy       : operation in progress (RUN or DONE)
//   done       : one-cycle completion pulse
//   sum, cout  : registered result and carry-out
//   ovf        : signed overflow (only with SERIAL_ADD_OVF_EN)
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] ps_next;

   serial_fa_cell u_cell (
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
   assign ps_next = {fa_s, ps_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ps_d    = ps_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sa_d    = a;
               sb_d    = b;
               c_d     = cin;
               cnt_d   = '0;
               ps_d    = '0;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            ps_d  = ps_next;
            c_d   = fa_co;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               sum_d   = ps_next;
               cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
               // c_q is the carry into the MSB on the final bit.
               ovf_d   = c_q ^ fa_co;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ps_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ps_q    <= ps_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Outputs decode registered state only; no input reaches an output.
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Scoreboard bench for serial_adder_ctrl (WIDTH=8). A reference model
//   on the rising edge records each accepted request with its arithmetic
//   result and the edge at which completion is due; a monitor on the
//   falling edge checks busy, done timing, results and result hold.
//   Define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               done_edge;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   int               total = 0;
   int               bad = 0;
   int               edge_n = 0;
   int               next_ok = 0;
   exp_t             q[$];
   exp_t             e_mon;
   exp_t             e_mod;
   logic [WIDTH-1:0] last_sum = '0;
   logic             last_cout = 1'b0;
   logic             last_ovf = 1'b0;
   logic             busy_exp;
   int               full;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, req);
      end
   endtask

   // Reference model: an operation is accepted when start is seen outside
   // the WIDTH+2 cycle window of the previous accepted one.
   always @(posedge clk) begin
      edge_n = edge_n + 1;
      if (rst_n && start && edge_n >= next_ok) begin
         full          = int'(a) + int'(b) + int'(cin);
         e_mod.sum     = full[WIDTH-1:0];
         e_mod.cout    = full[WIDTH];
         e_mod.ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (e_mod.sum[WIDTH-1] != a[WIDTH-1]);
         e_mod.done_edge = edge_n + WIDTH;
         q.push_back(e_mod);
         next_ok = edge_n + WIDTH + 2;
      end
   end

   // Monitor.
   always @(negedge clk) begin
      busy_exp = rst_n && (edge_n < next_ok - 1);
      check("busy", 32'(busy), 32'(busy_exp));
      if (done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e_mon = q.pop_front();
            check("done_time", edge_n, e_mon.done_edge);
            check("sum", 32'(sum), 32'(e_mon.sum));
            check("cout", 32'(cout), 32'(e_mon.cout));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(ovf), 32'(e_mon.ovf));
`endif
            last_sum  = e_mon.sum;
            last_cout = e_mon.cout;
            last_ovf  = e_mon.ovf;
         end
      end else begin
         if (q.size() > 0 && q[0].done_edge <= edge_n) begin
            check("missing_done", 32'd0, 32'd1);
            void'(q.pop_front());
         end
         check("sum_hold", 32'(sum), 32'(last_sum));
         check("cout_hold", 32'(cout), 32'(last_cout));
`ifdef SERIAL_ADD_OVF_EN
         check("ovf_hold", 32'(ovf), 32'(last_ovf));
`endif
      end
   end

   task automatic step(input logic s, input logic [WIDTH-1:0] aa,
                       input logic [WIDTH-1:0] bb, input logic c);
      @(negedge clk);
      #2;
      start = s;
      a     = aa;
      b     = bb;
      cin   = c;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      start     = 1'b0;
      q.delete();
      next_ok   = 0;
      last_sum  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      do_reset();
      idle(2);
      // Basic add, then carry-out boundaries.
      step(1'b1, 8'h3C, 8'h0F, 1'b0); idle(11);
      step(1'b1, 8'hFF, 8'h01, 1'b0); idle(11);
      step(1'b1, 8'hFF, 8'h00, 1'b1); idle(11);
      // Second request during an active operation is ignored.
      step(1'b1, 8'h22, 8'h33, 1'b0); idle(2);
      step(1'b1, 8'h11, 8'h00, 1'b0); idle(10);
      // Reset mid-operation, then a normal operation.
      step(1'b1, 8'hAA, 8'h55, 1'b1); idle(3);
      do_reset();
      idle(2);
      step(1'b1, 8'h12, 8'h34, 1'b0); idle(11);
      // start held high: back-to-back operations.
      repeat (25) step(1'b1, 8'h01, 8'h01, 1'b0);
      idle(12);
      // Signed overflow corners.
      step(1'b1, 8'h7F, 8'h01, 1'b0); idle(11);
      step(1'b1, 8'h80, 8'h80, 1'b0); idle(11);
      step(1'b1, 8'h10, 8'h20, 1'b0); idle(11);
      // Random traffic, including starts while busy.
      repeat (400) step($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
      idle(14);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
